sram_serial_loader: RTL and testbench

SRAM_SERIAL_LOADER -- requirements
Module: sram_serial_loader

---
 rtl/sram_serial_loader_if.sv | 22 ++
 rtl/sram_serial_loader.sv | 204 ++++++++++++++++++++
 tb/tb_sram_serial_loader.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_serial_loader_if.sv
// Target SRAM serial bus between the loader (master) and the SRAM macro (slave).
interface sram_serial_loader_if #(
  parameter int unsigned ADDR_W = 14
) ();
  logic [ADDR_W-1:0] tgt_addr;
  logic              tgt_cen;
  logic              tgt_wen;
  logic              tgt_din;
  logic              tgt_dout;
  logic              tgt_pause;
  logic              tgt_ramsel;

  modport master (
    output tgt_addr, tgt_cen, tgt_wen, tgt_din, tgt_pause, tgt_ramsel,
    input  tgt_dout
  );

  modport slave (
    input  tgt_addr, tgt_cen, tgt_wen, tgt_din, tgt_pause, tgt_ramsel,
    output tgt_dout
  );
endinterface

// File: rtl/sram_serial_loader.sv
// Serial SRAM loader: copies segmented source memory into a bit-serial target SRAM, then serves row readback.
// Optional running load checksum enabled by defining LOADER_CHECKSUM_EN.
module sram_serial_loader #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned N_SEG   = 2,
  parameter int unsigned GAP_CYC = 4,
  localparam int unsigned SEL_W  = (N_SEG > 1) ? $clog2(N_SEG) : 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    start,
  input  logic [N_SEG*ADDR_W-1:0] seg_len,
  input  logic [N_SEG*ADDR_W-1:0] seg_dst,
  output logic [ADDR_W-1:0]       src_addr,
  output logic [SEL_W-1:0]        src_sel,
  input  logic [WORD_W-1:0]       src_data,
  sram_serial_loader_if.master    sram,
  input  logic                    rd_start,
  input  logic [ADDR_W-1:0]       rd_base,
  input  logic [7:0]              rd_rows,
  output logic                    rd_trigger,
  output logic [WORD_W-1:0]       rd_word,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    done,
  output logic [WORD_W-1:0]       checksum
);

  localparam int unsigned CNT_MAX = (WORD_W > GAP_CYC) ? WORD_W : GAP_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] L_ADDR  = 4'd1;
  localparam logic [3:0] L_FETCH = 4'd2;
  localparam logic [3:0] L_SHIFT = 4'd3;
  localparam logic [3:0] L_GAP   = 4'd4;
  localparam logic [3:0] RUN     = 4'd5;
  localparam logic [3:0] R_ADDR  = 4'd6;
  localparam logic [3:0] R_SHIFT = 4'd7;
  localparam logic [3:0] R_GAP   = 4'd8;

  logic [3:0]              state;
  logic [N_SEG*ADDR_W-1:0] len_q, dst_q;
  logic [ADDR_W-1:0]       i_q, base_q, cur_len, cur_dst;
  logic [SEL_W-1:0]        k_q;
  logic [CNT_W-1:0]        cnt;
  logic [WORD_W-1:0]       sr;
  logic [7:0]              rows_q, r_q;
  logic [SEL_W:0]          first_seg, next_seg;
  logic                    fetch_cap, in_load, in_read;

  // Lowest-indexed segment at or above 'from' with a non-zero length; MSB flags "found".
  function automatic logic [SEL_W:0] find_seg(input logic [N_SEG*ADDR_W-1:0] lens,
                                              input int unsigned from);
    logic [SEL_W:0] res;
    int unsigned    s;
    res = '0;
    for (int unsigned j = 0; j < N_SEG; j++) begin
      s = N_SEG - 1 - j;
      if (s >= from && lens[s*ADDR_W +: ADDR_W] != '0) res = {1'b1, SEL_W'(s)};
    end
    return res;
  endfunction

  always_comb begin
    cur_len   = len_q[32'(k_q)*ADDR_W +: ADDR_W];
    cur_dst   = dst_q[32'(k_q)*ADDR_W +: ADDR_W];
    first_seg = find_seg(seg_len, 0);
    next_seg  = find_seg(len_q, 32'(k_q) + 32'd1);
    fetch_cap = (state == L_FETCH) && (cnt == CNT_W'(1));
    in_load   = (state == L_ADDR) || (state == L_FETCH) || (state == L_SHIFT) || (state == L_GAP);
    in_read   = (state == R_ADDR) || (state == R_SHIFT) || (state == R_GAP);
  end

  always_comb begin
    sram.tgt_addr   = in_load ? ADDR_W'(cur_dst + i_q)
                    : in_read ? ADDR_W'(base_q + ADDR_W'(r_q)) : '0;
    sram.tgt_cen    = !((state == L_SHIFT) || (state == R_SHIFT));
    sram.tgt_wen    = in_read;
    sram.tgt_din    = (state == L_SHIFT) && sr[WORD_W-1];
    sram.tgt_pause  = (state != RUN);
    sram.tgt_ramsel = (state != RUN);
    src_addr        = i_q;
    src_sel         = k_q;
    rd_trigger      = (state == R_SHIFT);
    rd_valid        = (state == R_GAP);
    busy            = (state != IDLE) && (state != RUN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      len_q   <= '0;
      dst_q   <= '0;
      i_q     <= '0;
      k_q     <= '0;
      cnt     <= '0;
      sr      <= '0;
      base_q  <= '0;
      rows_q  <= '0;
      r_q     <= '0;
      rd_word <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          len_q <= seg_len;
          dst_q <= seg_dst;
          i_q   <= '0;
          if (first_seg[SEL_W]) begin
            k_q   <= first_seg[SEL_W-1:0];
            state <= L_ADDR;
          end else begin
            state <= RUN;
            done  <= 1'b1;
          end
        end
        L_ADDR: begin
          cnt   <= '0;
          state <= L_FETCH;
        end
        L_FETCH: begin
          if (fetch_cap) begin
            sr    <= src_data;
            cnt   <= '0;
            state <= L_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        L_SHIFT: begin
          sr <= {sr[WORD_W-2:0], 1'b0};
          if (cnt == CNT_W'(WORD_W - 1)) begin
            cnt   <= '0;
            state <= L_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        L_GAP: begin
          if (cnt == CNT_W'(GAP_CYC - 1)) begin
            if (i_q == ADDR_W'(cur_len - ADDR_W'(1))) begin
              i_q <= '0;
              if (next_seg[SEL_W]) begin
                k_q   <= next_seg[SEL_W-1:0];
                state <= L_ADDR;
              end else begin
                state <= RUN;
                done  <= 1'b1;
              end
            end else begin
              i_q   <= i_q + 1'b1;
              state <= L_ADDR;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: if (rd_start) begin
          base_q <= rd_base;
          rows_q <= rd_rows;
          r_q    <= '0;
          if (rd_rows == 8'd0) done  <= 1'b1;
          else                 state <= R_ADDR;
        end
        R_ADDR: begin
          cnt   <= '0;
          state <= R_SHIFT;
        end
        R_SHIFT: begin
          rd_word <= {rd_word[WORD_W-2:0], sram.tgt_dout};
          if (cnt == CNT_W'(WORD_W - 1)) state <= R_GAP;
          else                           cnt   <= cnt + 1'b1;
        end
        R_GAP: begin
          if (r_q == rows_q - 8'd1) begin
            state <= RUN;
            done  <= 1'b1;
          end else begin
            r_q   <= r_q + 8'd1;
            state <= R_ADDR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] csum_q;

  always_ff @(posedge CLK) begin
    if (RST || (state == IDLE && start)) csum_q <= '0;
    else if (fetch_cap)                  csum_q <= csum_q + src_data;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_sram_serial_loader.sv
// Directed bench for sram_serial_loader: scoreboarded target writes and readback rows, latency and reset checks.
module tb_sram_serial_loader;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned N_SEG   = 2;
  localparam int unsigned GAP_CYC = 4;
  localparam int unsigned LAT     = 3 + WORD_W + GAP_CYC;
  localparam int unsigned RD_ROW  = 1 + WORD_W + 1;
  localparam int          LIMIT   = 2000;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } xfer_t;

  logic                    CLK = 1'b0;
  logic                    RST, start, rd_start;
  logic [N_SEG*ADDR_W-1:0] seg_len, seg_dst;
  logic [ADDR_W-1:0]       src_addr, rd_base;
  logic [0:0]              src_sel;
  logic [WORD_W-1:0]       src_data, rd_word, checksum;
  logic [7:0]              rd_rows;
  logic                    rd_trigger, rd_valid, busy, done;

  logic [WORD_W-1:0] src_mem [N_SEG][8];
  logic [WORD_W-1:0] rd_pattern, exp_sum;
  xfer_t             wq[$], rq[$];
  int                checks = 0, errors = 0;
  int                cen_low_cycles = 0, wr_windows = 0;

  always #5 CLK = ~CLK;

  sram_serial_loader_if #(.ADDR_W(ADDR_W)) sram ();

  sram_serial_loader #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .N_SEG(N_SEG), .GAP_CYC(GAP_CYC)
  ) u_dut (
    .CLK(CLK), .RST(RST), .start(start), .seg_len(seg_len), .seg_dst(seg_dst),
    .src_addr(src_addr), .src_sel(src_sel), .src_data(src_data), .sram(sram),
    .rd_start(rd_start), .rd_base(rd_base), .rd_rows(rd_rows), .rd_trigger(rd_trigger),
    .rd_word(rd_word), .rd_valid(rd_valid), .busy(busy), .done(done), .checksum(checksum)
  );

  // Source memory with one-cycle read latency.
  always @(posedge CLK) src_data <= src_mem[src_sel][src_addr[2:0]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] csum_model(input logic [WORD_W-1:0] s);
`ifdef LOADER_CHECKSUM_EN
    return s;
`else
    return '0;
`endif
  endfunction

  // Write monitor: collect each low-cen write window MSB first and score it.
  logic [WORD_W-1:0] wbits = '0;
  logic [ADDR_W-1:0] waddr = '0;
  int                wcnt = 0;
  xfer_t             wexp;
  always @(negedge CLK) begin
    if (RST) begin
      wcnt = 0;
    end else if (!sram.tgt_cen && !sram.tgt_wen) begin
      wbits = {wbits[WORD_W-2:0], sram.tgt_din};
      waddr = sram.tgt_addr;
      wcnt++;
    end else if (wcnt != 0) begin
      wr_windows++;
      check("wr_window_len", wcnt, WORD_W);
      check("wr_pending", wq.size() != 0, 1);
      if (wq.size() != 0) begin
        wexp = wq.pop_front();
        check("wr_addr", waddr, wexp.addr);
        check("wr_data", wbits, wexp.data);
      end
      wcnt = 0;
    end
    if (!RST && !sram.tgt_cen) cen_low_cycles++;
  end

  // Readback responder and monitor: replay rd_pattern MSB first per trigger window.
  int    tcnt = 0;
  xfer_t rexp;
  initial sram.tgt_dout = 1'b0;
  always @(negedge CLK) begin
    if (RST) begin
      tcnt = 0;
    end else begin
      if (rd_trigger) begin
        if (tcnt < WORD_W) sram.tgt_dout = rd_pattern[WORD_W-1-tcnt];
        tcnt++;
      end else if (tcnt != 0) begin
        check("trig_window_len", tcnt, WORD_W);
        tcnt = 0;
      end
      if (rd_valid) begin
        check("rd_pending", rq.size() != 0, 1);
        check("rd_wen", sram.tgt_wen, 1);
        if (rq.size() != 0) begin
          rexp = rq.pop_front();
          check("rd_addr", sram.tgt_addr, rexp.addr);
          check("rd_word", rd_word, rexp.data);
        end
      end
    end
  end

  task automatic check_reset(input string pfx);
    check({pfx, "_cen"},      sram.tgt_cen, 1);
    check({pfx, "_pause"},    sram.tgt_pause, 1);
    check({pfx, "_ramsel"},   sram.tgt_ramsel, 1);
    check({pfx, "_wen"},      sram.tgt_wen, 0);
    check({pfx, "_din"},      sram.tgt_din, 0);
    check({pfx, "_tgt_addr"}, sram.tgt_addr, 0);
    check({pfx, "_src_addr"}, src_addr, 0);
    check({pfx, "_src_sel"},  src_sel, 0);
    check({pfx, "_trigger"},  rd_trigger, 0);
    check({pfx, "_rd_word"},  rd_word, 0);
    check({pfx, "_rd_valid"}, rd_valid, 0);
    check({pfx, "_busy"},     busy, 0);
    check({pfx, "_done"},     done, 0);
    check({pfx, "_checksum"}, checksum, 0);
  endtask

  task automatic push_seg(input int k, input logic [ADDR_W-1:0] len, input logic [ADDR_W-1:0] dst);
    for (int i = 0; i < int'(len); i++) begin
      wq.push_back({ADDR_W'(dst + ADDR_W'(i)), src_mem[k][i]});
      exp_sum = exp_sum + src_mem[k][i];
    end
  endtask

  // Start raised at negedge N0 and sampled at the next posedge; n counts negedges until done is seen.
  task automatic run_load(input logic [ADDR_W-1:0] len0, dst0, len1, dst1,
                          output int n, output logic busy1);
    seg_len = {len1, len0};
    seg_dst = {dst1, dst0};
    exp_sum = '0;
    push_seg(0, len0, dst0);
    push_seg(1, len1, dst1);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    busy1 = busy;
    n = 1;
    while (!done && n < LIMIT) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic run_read(input logic [ADDR_W-1:0] base, input logic [7:0] rows,
                          input logic [WORD_W-1:0] pattern, output int n, output logic pause1,
                          output logic wen1);
    rd_pattern = pattern;
    for (int r = 0; r < int'(rows); r++) rq.push_back({ADDR_W'(base + ADDR_W'(r)), pattern});
    rd_base  = base;
    rd_rows  = rows;
    rd_start = 1'b1;
    @(negedge CLK);
    rd_start = 1'b0;
    pause1   = sram.tgt_pause;
    wen1     = sram.tgt_wen;
    n = 1;
    while (!done && n < LIMIT) begin
      @(negedge CLK);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, k, cen_before;
    logic b1, p1, w1;
    RST = 1'b1; start = 1'b0; rd_start = 1'b0;
    seg_len = '0; seg_dst = '0; rd_base = '0; rd_rows = '0;
    rd_pattern = '0; exp_sum = '0;
    src_mem[0][0] = 32'hA500_0001; src_mem[0][1] = 32'h1234_5678; src_mem[0][2] = 32'h0F0F_0F0F;
    src_mem[1][0] = 32'hDEAD_BEEF; src_mem[1][1] = 32'h0000_0003;
    for (int i = 3; i < 8; i++) src_mem[0][i] = '0;
    for (int i = 2; i < 8; i++) src_mem[1][i] = '0;
    repeat (3) @(negedge CLK);
    check_reset("rst");
    RST = 1'b0;
    @(negedge CLK);

    // Two segments: 3 words at 0, 2 words at 5000.
    run_load(14'd3, 14'd0, 14'd2, 14'd5000, n, b1);
    check("load_done_latency", n, 5 * LAT + 1);
    check("load_busy", b1, 1);
    check("load_windows", wr_windows, 5);
    check("load_queue_empty", wq.size(), 0);
    check("load_checksum", checksum, csum_model(exp_sum));
    check("run_pause", sram.tgt_pause, 0);
    check("run_ramsel", sram.tgt_ramsel, 0);
    check("run_busy", busy, 0);
    @(negedge CLK);
    check("load_done_pulse", done, 0);

    // start is ignored outside IDLE.
    cen_before = cen_low_cycles;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    check("run_start_ignored_busy", busy, 0);
    check("run_start_ignored_cen", cen_low_cycles, cen_before);

    run_read(14'd2000, 8'd8, 32'h0000_00FF, n, p1, w1);
    check("read_pause", p1, 1);
    check("read_wen", w1, 1);
    check("read_done_latency", n, 8 * RD_ROW + 1);
    check("read_queue_empty", rq.size(), 0);
    check("read_end_pause", sram.tgt_pause, 0);
    check("read_end_ramsel", sram.tgt_ramsel, 0);
    check("read_end_wen", sram.tgt_wen, 0);

    // Address wraps past the top of the target.
    run_read(14'd16383, 8'd2, 32'h8000_0001, n, p1, w1);
    check("wrap_done_latency", n, 2 * RD_ROW + 1);
    check("wrap_queue_empty", rq.size(), 0);

    rd_rows  = 8'd0;
    rd_start = 1'b1;
    @(negedge CLK);
    rd_start = 1'b0;
    check("zero_rows_done", done, 1);
    check("zero_rows_busy", busy, 0);
    check("zero_rows_pause", sram.tgt_pause, 0);
    @(negedge CLK);
    check("zero_rows_done_pulse", done, 0);

    // All-zero segments go straight to RUN.
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check_reset("rst2");
    RST = 1'b0;
    @(negedge CLK);
    cen_before = cen_low_cycles;
    run_load(14'd0, 14'd7, 14'd0, 14'd9, n, b1);
    check("zero_seg_done_latency", n, 1);
    check("zero_seg_busy", b1, 0);
    @(negedge CLK);
    check("zero_seg_done_pulse", done, 0);
    check("zero_seg_no_cen", cen_low_cycles, cen_before);
    check("zero_seg_pause", sram.tgt_pause, 0);

    // Reset during cycle 20 of the first L_SHIFT, then reload.
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    src_mem[0][0] = 32'hFFFF_FFFF;
    src_mem[0][1] = 32'h0000_0002;
    seg_len = {14'd0, 14'd2};
    seg_dst = {14'd0, 14'd100};
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    k = 0;
    n = 0;
    while (k < 20 && n < LIMIT) begin
      @(negedge CLK);
      n++;
      if (!sram.tgt_cen) k++;
    end
    check("abort_reached_shift", k, 20);
    RST = 1'b1;
    @(negedge CLK);
    check_reset("abort");
    RST = 1'b0;
    @(negedge CLK);
    run_load(14'd2, 14'd100, 14'd0, 14'd0, n, b1);
    check("reload_done_latency", n, 2 * LAT + 1);
    check("reload_queue_empty", wq.size(), 0);
    check("reload_checksum", checksum, csum_model(exp_sum));

    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
